// File: rtl/systolic_result_drain.sv
// Result drain for the NxN systolic MAC array: waits LAT cycles after start, snapshots all
// accumulators at once, then streams them over valid/ready. Define DRAIN_COLMAJOR_EN for column-major beat order.
module systolic_result_drain #(
    parameter int DW  = 8,
    parameter int N   = 3,
    parameter int LAT = 7,
    parameter int IW  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N*N*DW-1:0] res_flat,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DW-1:0]     m_data,
    output logic [IW-1:0]     m_index,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic              start_err
);

    // state  | meaning
    // IDLE   | waiting for start from the feeder
    // WAIT   | latency counter running down to the snapshot edge
    // STREAM | presenting snapshot elements one per beat
    typedef enum logic [1:0] {IDLE, WAIT, STREAM} state_t;

    localparam logic [IW-1:0] LAST_BEAT = IW'(N*N - 1);

    state_t              state, state_nxt;
    logic [7:0]          cnt;
    logic [IW-1:0]       beat;
    logic [IW-1:0]       beat_nxt;
    logic [IW-1:0]       idx_nxt;
    logic [N*N*DW-1:0]   snap;
    logic                fire;

    // Maps beat number to the row-major element index that beat carries.
    function automatic logic [IW-1:0] idx_of(input logic [IW-1:0] k);
`ifdef DRAIN_COLMAJOR_EN
        int kk;
        kk = int'(k);
        return IW'((kk % N) * N + kk / N);
`else
        return k;
`endif
    endfunction

    assign fire     = m_valid && m_ready;
    assign beat_nxt = beat + 1'b1;
    assign idx_nxt  = idx_of(beat_nxt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            beat      <= '0;
            snap      <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_index   <= '0;
            done      <= 1'b0;
            start_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            done      <= 1'b0;
            start_err <= start && (state != IDLE);
            case (state)
                IDLE: begin
                    if (start) cnt <= 8'(LAT - 1);
                end
                WAIT: begin
                    if (cnt == 8'd0) begin
                        snap    <= res_flat;
                        beat    <= '0;
                        m_index <= idx_of('0);
                        m_data  <= res_flat[DW-1:0];
                        m_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                STREAM: begin
                    if (fire) begin
                        if (beat == LAST_BEAT) begin
                            m_valid <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            beat    <= beat_nxt;
                            m_index <= idx_nxt;
                            m_data  <= snap[idx_nxt*DW +: DW];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = WAIT;
            WAIT:    if (cnt == 8'd0) state_nxt = STREAM;
            STREAM:  if (fire && beat == LAST_BEAT) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != IDLE);
        m_last = m_valid && (beat == LAST_BEAT);
    end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Scoreboard bench for systolic_result_drain: stimulus pushes expected beats, a negedge monitor
// pops and compares on every handshake and checks stall holding and done timing.
module tb_systolic_result_drain;

    localparam int DW  = 8;
    localparam int N   = 3;
    localparam int LAT = 7;
    localparam int IW  = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] index;
        logic          last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [N*N*DW-1:0] res_flat;
    logic              m_valid;
    logic              m_ready;
    logic [DW-1:0]     m_data;
    logic [IW-1:0]     m_index;
    logic              m_last;
    logic              busy;
    logic              done;
    logic              start_err;

    systolic_result_drain #(.DW(DW), .N(N), .LAT(LAT), .IW(IW)) dut (
        .clk(clk), .rst(rst), .start(start), .res_flat(res_flat),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index),
        .m_last(m_last), .busy(busy), .done(done), .start_err(start_err)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_pass   = 0;
    beat_t q[$];
`ifdef DRAIN_COLMAJOR_EN
    int    order[9] = '{0, 3, 6, 1, 4, 7, 2, 5, 8};
`else
    int    order[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
`endif
    logic  rpat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic  rmode = 1'b0;
    int    rcnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
        if (rmode) begin
            m_ready = rpat[rcnt];
            rcnt = (rcnt + 1) % 4;
        end
    endtask

    task automatic set_res(input int base);
        for (int i = 0; i < N*N; i++) res_flat[i*DW +: DW] = 8'(base + i);
    endtask

    task automatic push_exp(input int base);
        beat_t e;
        for (int k = 0; k < N*N; k++) begin
            e.data  = 8'(base + order[k]);
            e.index = 4'(order[k]);
            e.last  = (k == N*N - 1);
            q.push_back(e);
        end
    endtask

    task automatic start_matrix(input int base);
        set_res(base);
        push_exp(base);
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_cycles);
        int i;
        for (i = 1; i <= 300; i++) begin
            cyc();
            if (done) break;
        end
        if (exp_cycles >= 0) check(name, i, exp_cycles);
        else check(name, (i <= 300), 1);
    endtask

    // Monitor: handshake scoreboard, stall hold, done one cycle after last beat.
    logic          exp_done = 1'b0;
    logic          held = 1'b0;
    logic [DW-1:0] hd;
    logic [IW-1:0] hi;
    beat_t         e;
    always @(negedge clk) begin
        if (rst) begin
            exp_done = 1'b0;
            held     = 1'b0;
        end else begin
            check("done_pulse", done, exp_done);
            if (held) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, hd);
                check("hold_index", m_index, hi);
            end
            exp_done = 1'b0;
            held     = 1'b0;
            if (m_valid && m_ready) begin
                if (q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_beat: got data %0h index %0d with nothing expected", m_data, m_index);
                end else begin
                    e = q.pop_front();
                    check("beat_data", m_data, e.data);
                    check("beat_index", m_index, e.index);
                    check("beat_last", m_last, e.last);
                    exp_done = e.last;
                end
            end else if (m_valid) begin
                held = 1'b1;
                hd   = m_data;
                hi   = m_index;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int i;
        rst = 1'b1; start = 1'b0; m_ready = 1'b0; res_flat = '0;
        repeat (3) cyc();
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_index", m_index, 0);
        check("rst_flags", {m_last, busy, done, start_err}, 0);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            check("idle", {m_valid, busy, done, start_err}, 0);
        end

        // Capture edge: only values present exactly LAT edges after start are kept.
        m_ready = 1'b1;
        res_flat = {N*N{8'hEE}};
        push_exp(1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("wait_busy", busy, 1);
        for (int k = 1; k <= LAT - 1; k++) begin
            cyc();
            check("wait_novalid", m_valid, 0);
            if (k == LAT - 1) set_res(1);
        end
        cyc();
        check("cap_valid", m_valid, 1);
        check("cap_data", m_data, 1);
        check("cap_index", m_index, 0);
        res_flat = {N*N{8'hFF}};
        wait_done("done_latency_a", N*N);
        check("idle_after_a", busy, 0);

        // Start while busy, in WAIT and in a stalled STREAM, then on the last handshake.
        start_matrix(32'h20);
        m_ready = 1'b0;
        cyc(); cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("err_wait", start_err, 1);
        check("err_wait_busy", busy, 1);
        cyc();
        check("err_wait_clear", start_err, 0);
        for (i = 0; i < 20; i++) begin
            if (m_valid) break;
            cyc();
        end
        check("stream_reached", m_valid, 1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("err_stream", start_err, 1);
        check("err_stream_index", m_index, 0);
        check("err_stream_data", m_data, 8'h20);
        m_ready = 1'b1;
        for (i = 0; i < 30; i++) begin
            if (m_last) break;
            cyc();
        end
        check("last_reached", m_last, 1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("err_last", start_err, 1);
        check("err_last_busy", busy, 0);
        check("err_last_done", done, 1);

        // Start on the done cycle is accepted; then reset mid-stream at beat 4.
        start_matrix(32'h30);
        check("done_cycle_start", busy, 1);
        check("done_cycle_noerr", start_err, 0);
        for (i = 0; i < 40; i++) begin
            cyc();
            if (m_valid && m_index == 4'd4) break;
        end
        check("beat4_reached", m_index, 4);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("midrst_valid", m_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_out", {m_last, done, m_index, m_data}, 0);
        q.delete();
        repeat (5) cyc();

        start_matrix(32'h40);
        wait_done("done_latency_b", LAT + N*N);

        // Backpressure 1,0,0,1 repeating.
        rcnt  = 0;
        rmode = 1'b1;
        start_matrix(32'h50);
        wait_done("done_bp", -1);
        rmode = 1'b0;
        m_ready = 1'b1;
        repeat (3) cyc();
        check("queue_empty", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
